// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the 16-bit core: datapath and
//                register-address widths, condition-flag bit positions and
//                the flag-vector type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    // Bit positions inside the architectural flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    typedef logic [2:0] flag_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/flag_reg.sv
`default_nettype none
// ============================================================================
//  Module      : flag_reg
//  Description : Architectural condition-flag register (Z, V, N). The Z bit
//                and the V/N pair have independent write enables; with both
//                enables low the flags hold indefinitely.
//  Ports       : clk, rst (async, active-high)
//                z_en   - write Z from z_in
//                vn_en  - write V from v_in and N from n_in
//                flags  - current flag vector (index with FLAG_* constants)
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  z_en,
    input  logic  vn_en,
    input  logic  z_in,
    input  logic  v_in,
    input  logic  n_in,
    output flag_t flags
);

    flag_t r_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else begin
            if (z_en) begin
                r_flags[FLAG_Z] <= z_in;
            end
            if (vn_en) begin
                r_flags[FLAG_V] <= v_in;
                r_flags[FLAG_N] <= n_in;
            end
        end
    end

    assign flags = r_flags;

endmodule : flag_reg
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pipe
//  Description : EX/MEM pipeline register of the 16-bit core. Captures the
//                shifter/ALU result, memory/writeback controls and store
//                data, and owns the Z/V/N condition flags read by branch
//                resolution. Edge priority: flush > stall > load.
//  Ports       : clk, rst (async, active-high), stall, flush
//                EX side : in_valid, ex_result, ex_zr, ex_ov, ex_neg, set_z,
//                          set_vn, mem_re_in, mem_we_in, wb_we_in, wb_dst_in,
//                          store_data_in
//                MEM side: out_valid, mem_result, mem_re, mem_we, wb_we,
//                          wb_dst, store_data, flag_z, flag_v, flag_n
//  Options     : EX_MEM_STALL_CNT_EN - adds a saturating 16-bit stall_cnt
//                output counting stall edges that are not flushed.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_zr,
    input  logic              ex_ov,
    input  logic              ex_neg,
    input  logic              set_z,
    input  logic              set_vn,
    input  logic              mem_re_in,
    input  logic              mem_we_in,
    input  logic              wb_we_in,
    input  logic [REG_AW-1:0] wb_dst_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic              mem_re,
    output logic              mem_we,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_dst,
    output logic [DATA_W-1:0] store_data,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    import cpu_pkg::*;

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_mem_re;
    logic              r_mem_we;
    logic              r_wb_we;
    logic [REG_AW-1:0] r_wb_dst;
    logic [DATA_W-1:0] r_store_data;

    logic  w_load;
    logic  w_flag_load;
    flag_t w_flags;

    assign w_load      = !flush && !stall;
    // Only a real instruction may touch the architectural flags
    assign w_flag_load = w_load && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_dst     <= '0;
            r_store_data <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_dst     <= '0;
            r_store_data <= '0;
        end else if (!stall) begin
            r_valid      <= in_valid;
            r_result     <= ex_result;
            // Gate side-effecting controls so an empty slot never acts
            r_mem_re     <= mem_re_in & in_valid;
            r_mem_we     <= mem_we_in & in_valid;
            r_wb_we      <= wb_we_in  & in_valid;
            r_wb_dst     <= wb_dst_in;
            r_store_data <= store_data_in;
        end
    end

    flag_reg u_flag_reg (
        .clk   (clk),
        .rst   (rst),
        .z_en  (w_flag_load && set_z),
        .vn_en (w_flag_load && set_vn),
        .z_in  (ex_zr),
        .v_in  (ex_ov),
        .n_in  (ex_neg),
        .flags (w_flags)
    );

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign out_valid  = r_valid;
    assign mem_result = r_result;
    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign wb_we      = r_wb_we;
    assign wb_dst     = r_wb_dst;
    assign store_data = r_store_data;
    assign flag_z     = w_flags[FLAG_Z];
    assign flag_v     = w_flags[FLAG_V];
    assign flag_n     = w_flags[FLAG_N];

`ifndef SYNTHESIS
    // Simultaneous load and store is an illegal encoding from decode
    a_no_re_we : assert property (@(posedge clk) disable iff (rst) !(mem_re && mem_we));
`endif

endmodule : ex_mem_pipe
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_pipe
//  Description : Self-checking bench for ex_mem_pipe. Each driven cycle pushes
//                the expected MEM-stage state to a scoreboard queue; the
//                entry is popped and compared just after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe;

    logic        clk;
    logic        rst;
    logic        stall, flush, in_valid;
    logic [15:0] ex_result;
    logic        ex_zr, ex_ov, ex_neg, set_z, set_vn;
    logic        mem_re_in, mem_we_in, wb_we_in;
    logic [3:0]  wb_dst_in;
    logic [15:0] store_data_in;
    logic        out_valid;
    logic [15:0] mem_result;
    logic        mem_re, mem_we, wb_we;
    logic [3:0]  wb_dst;
    logic [15:0] store_data;
    logic        flag_z, flag_v, flag_n;
`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    ex_mem_pipe #(.DATA_W(16), .REG_AW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .ex_result     (ex_result),
        .ex_zr         (ex_zr),
        .ex_ov         (ex_ov),
        .ex_neg        (ex_neg),
        .set_z         (set_z),
        .set_vn        (set_vn),
        .mem_re_in     (mem_re_in),
        .mem_we_in     (mem_we_in),
        .wb_we_in      (wb_we_in),
        .wb_dst_in     (wb_dst_in),
        .store_data_in (store_data_in),
        .out_valid     (out_valid),
        .mem_result    (mem_result),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .wb_we         (wb_we),
        .wb_dst        (wb_dst),
        .store_data    (store_data),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_n        (flag_n)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] res;
        logic        re, we, wwe;
        logic [3:0]  dst;
        logic [15:0] sd;
        logic        fz, fv, fn;
        logic [15:0] cnt;
    } exp_t;

    exp_t m;          // reference model state
    exp_t sb_q[$];    // scoreboard
    int   n_checks;
    int   n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m = '{valid:1'b0, res:16'h0, re:1'b0, we:1'b0, wwe:1'b0, dst:4'h0,
              sd:16'h0, fz:1'b0, fv:1'b0, fn:1'b0, cnt:16'h0};
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ".valid"}, 32'(out_valid),  32'(e.valid));
        check({tag, ".res"},   32'(mem_result), 32'(e.res));
        check({tag, ".re"},    32'(mem_re),     32'(e.re));
        check({tag, ".we"},    32'(mem_we),     32'(e.we));
        check({tag, ".wbwe"},  32'(wb_we),      32'(e.wwe));
        check({tag, ".dst"},   32'(wb_dst),     32'(e.dst));
        check({tag, ".sd"},    32'(store_data), 32'(e.sd));
        check({tag, ".fz"},    32'(flag_z),     32'(e.fz));
        check({tag, ".fv"},    32'(flag_v),     32'(e.fv));
        check({tag, ".fn"},    32'(flag_n),     32'(e.fn));
`ifdef EX_MEM_STALL_CNT_EN
        check({tag, ".cnt"},   32'(stall_cnt),  32'(e.cnt));
`endif
    endtask

    // Drive one cycle, advance the model on the edge, then pop and compare.
    task automatic step(input string tag, input logic st, input logic fl, input logic iv,
                        input logic [15:0] res, input logic zr, input logic ov, input logic neg,
                        input logic sz, input logic svn, input logic re, input logic we,
                        input logic wwe, input logic [3:0] dst, input logic [15:0] sd);
        exp_t e;
        stall = st; flush = fl; in_valid = iv; ex_result = res;
        ex_zr = zr; ex_ov = ov; ex_neg = neg; set_z = sz; set_vn = svn;
        mem_re_in = re; mem_we_in = we; wb_we_in = wwe; wb_dst_in = dst;
        store_data_in = sd;
        @(posedge clk);
        if (fl) begin
            m.valid = 1'b0; m.res = 16'h0; m.re = 1'b0; m.we = 1'b0;
            m.wwe = 1'b0; m.dst = 4'h0; m.sd = 16'h0;
        end else if (!st) begin
            m.valid = iv; m.res = res; m.re = re & iv; m.we = we & iv;
            m.wwe = wwe & iv; m.dst = dst; m.sd = sd;
            if (iv && sz) m.fz = zr;
            if (iv && svn) begin
                m.fv = ov;
                m.fn = neg;
            end
        end
        if (st && !fl && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        sb_q.push_back(m);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            compare_all(tag, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        stall = 0; flush = 0; in_valid = 0; ex_result = 0; ex_zr = 0; ex_ov = 0;
        ex_neg = 0; set_z = 0; set_vn = 0; mem_re_in = 0; mem_we_in = 0;
        wb_we_in = 0; wb_dst_in = 0; store_data_in = 0;
        model_reset();
        rst = 1'b1;
        #1;
        compare_all("por", m);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Load a zero result with Z update and writeback
        step("ld_zero", 0,0,1, 16'h0000, 1,0,0, 1,0, 0,0,1, 4'h3, 16'h0000);
        // Negative result, V/N update only; Z must stay set
        step("ld_neg",  0,0,1, 16'h8000, 0,1,1, 0,1, 0,0,1, 4'h5, 16'hA5A5);
        // Load instruction, nonzero positive result
        step("ld_load", 0,0,1, 16'h0042, 0,0,0, 0,1, 1,0,1, 4'h7, 16'h0000);
        // Store, no flag update
        step("ld_store",0,0,1, 16'h0100, 0,0,0, 0,0, 0,1,0, 4'h2, 16'hBEEF);

        // Three stalls while inputs change: everything frozen
        for (int i = 0; i < 3; i++)
            step("stall",  1,0,1, 16'h1234, 0,0,0, 1,0, 0,0,1, 4'h9, 16'h5555);
        // Release: new value appears and Z clears
        step("release", 0,0,1, 16'h1234, 0,0,0, 1,0, 0,0,1, 4'h9, 16'h5555);

        // Flush beats stall; flags unchanged
        step("fl_st",   1,1,1, 16'h7777, 1,1,1, 1,1, 0,0,1, 4'hF, 16'h1111);
        // Invalid slot: controls gated, flags untouched
        step("invalid", 0,0,0, 16'h0F0F, 1,0,0, 1,1, 0,1,1, 4'h4, 16'h2222);
        // Set Z once more for the reset check below
        step("ld_z",    0,0,1, 16'h0000, 1,0,0, 1,0, 0,0,1, 4'h1, 16'h0000);

        // Asynchronous reset mid-cycle with out_valid=1 and flag_z=1
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst", m);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 0,0,0, 16'hFFFF, 1,1,1, 1,1, 1,0,1, 4'hE, 16'hFFFF);

`ifdef EX_MEM_STALL_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++)
            step("cnt5",  1,0,0, 16'h0, 0,0,0, 0,0, 0,0,0, 4'h0, 16'h0);
        // Fast-forward to 16'hFFFE
        stall = 1'b1;
        repeat (16'hFFFE - 5) @(posedge clk);
        m.cnt = 16'hFFFE;
        #1;
        check("cnt_fffe", 32'(stall_cnt), 32'(m.cnt));
        for (int i = 0; i < 3; i++)
            step("cnt_sat", 1,0,0, 16'h0, 0,0,0, 0,0, 0,0,0, 4'h0, 16'h0);
        do_reset();
        step("cnt_a",   1,0,0, 16'h0, 0,0,0, 0,0, 0,0,0, 4'h0, 16'h0);
        step("cnt_fl",  1,1,0, 16'h0, 0,0,0, 0,0, 0,0,0, 4'h0, 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_mem_pipe
`default_nettype wire
